prco_seq_ctrl: RTL

Multi-cycle instruction sequencer for the PRCO core. It fetches 16-bit instruction words over a request/acknowledge port and steps the registered `prco_decoder` through one enable pulse per instruction. It then gives the ALU and register file their enable and write strobes in fixed slots. Program counter update, jumps, halt and fetch timeout are also handled here.

---
 rtl/prco_seq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/prco_seq_ctrl.sv
// prco_seq_ctrl: multi-cycle instruction sequencer for the PRCO core.
// Fetches 16-bit words over a req/ack port and steps the external decoder,
// ALU and register file through FETCH, DECODE, EXEC and WB. It also handles
// PC update, absolute jumps, halt and a fetch timeout that faults the core.
module prco_seq_ctrl #(
  parameter int              PC_W          = 8,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter logic [4:0]      HALT_OP       = 5'h1F,
  parameter logic [4:0]      JMP_OP        = 5'h1E,
  parameter int              FETCH_TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  output logic            q_mem_req,
  output logic [PC_W-1:0] q_pc,
  input  logic            i_mem_ack,
  input  logic [15:0]     i_instr,
  output logic [15:0]     q_ir,
  output logic            q_dec_en,
  input  logic [4:0]      i_dec_op,
  input  logic            i_dec_reg_we,
  output logic            q_alu_en,
  output logic            q_reg_we,
  output logic [2:0]      q_state,
  output logic            q_halted,
  output logic            q_fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(FETCH_TIMEOUT);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [7:0]      r_cnt;
  logic            r_we;
  logic            r_halted;
  logic            r_fault;

  logic [7:0]      w_cnt_next;
  logic [PC_W-1:0] w_jmp_pc;
  logic [PC_W-1:0] w_pc_inc;

  assign w_cnt_next = r_cnt + 8'd1;
  assign w_pc_inc   = r_pc + PC_W'(1);

  // Jump target: imm8 zero-extended or truncated to the PC width
  always_comb begin
    w_jmp_pc = '0;
    for (int b = 0; b < PC_W && b < 8; b++) begin
      w_jmp_pc[b] = r_ir[b];
    end
  end

  // Sequencer FSM with PC, IR, timeout counter and sticky flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_en) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_mem_ack) begin
            r_ir    <= i_instr;
            r_cnt   <= '0;
            r_state <= S_DECODE;
          end else if (w_cnt_next == TIMEOUT_LIM) begin
            r_cnt    <= w_cnt_next;
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_we <= i_dec_reg_we;
          if (i_dec_op == HALT_OP) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (i_dec_op == JMP_OP) begin
            r_pc    <= w_jmp_pc;
            r_state <= i_en ? S_FETCH : S_IDLE;
          end else begin
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_pc    <= w_pc_inc;
          r_state <= i_en ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign q_mem_req = (r_state == S_FETCH);
  assign q_dec_en  = (r_state == S_DECODE);
  assign q_alu_en  = (r_state == S_EXEC);
  assign q_reg_we  = (r_state == S_WB) && r_we;
  assign q_state   = r_state;
  assign q_pc      = r_pc;
  assign q_ir      = r_ir;
  assign q_halted  = r_halted;
  assign q_fault   = r_fault;

endmodule
